// File: rtl/dual_fifo_bank.sv
// dual_fifo_bank: two independent synchronous FIFOs sharing one read/write strobe pair, steered by fifo_choose.
// Define DUAL_FIFO_ERR_EN to add err_clr and the sticky fifoN_ovf / fifoN_udf flags.
module dual_fifo_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef DUAL_FIFO_ERR_EN
    input  logic                     err_clr,
    output logic                     fifo1_ovf,
    output logic                     fifo1_udf,
    output logic                     fifo2_ovf,
    output logic                     fifo2_udf,
`endif
    input  logic                     fifo_rd_en,
    input  logic                     fifo_wr_en,
    input  logic                     fifo_choose,
    input  logic [DATA_W-1:0]        fifo1_wr_data,
    input  logic [DATA_W-1:0]        fifo2_wr_data,
    output logic [DATA_W-1:0]        fifo1_rd_data,
    output logic [DATA_W-1:0]        fifo2_rd_data,
    output logic                     fifo1_full,
    output logic                     fifo1_empty,
    output logic                     fifo2_full,
    output logic                     fifo2_empty,
    output logic [$clog2(DEPTH):0]   fifo1_count,
    output logic [$clog2(DEPTH):0]   fifo2_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        localparam logic ID = 1'(g);

        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] wr_data;
        logic [DATA_W-1:0] rd_data;
        logic [AW-1:0]     wptr;
        logic [AW-1:0]     rptr;
        logic [AW:0]       count;
        logic [AW:0]       count_nxt;
        logic              full;
        logic              empty;
        logic              sel;
        logic              rd_acc;
        logic              wr_acc;

        assign wr_data = (g == 0) ? fifo1_wr_data : fifo2_wr_data;
        assign sel     = (fifo_choose == ID);
        assign rd_acc  = sel & fifo_rd_en & ~empty;
        // A read in the same cycle frees the slot, so a full FIFO still takes the write.
        assign wr_acc  = sel & fifo_wr_en & (~full | rd_acc);

        always_comb begin
            count_nxt = count;
            if (wr_acc & ~rd_acc) begin
                count_nxt = count + 1'b1;
            end else if (rd_acc & ~wr_acc) begin
                count_nxt = count - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_acc) begin
                mem[wptr] <= wr_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr    <= '0;
                rptr    <= '0;
                count   <= '0;
                full    <= 1'b0;
                empty   <= 1'b1;
                rd_data <= '0;
            end else begin
                if (wr_acc) begin
                    wptr <= wptr + 1'b1;
                end
                if (rd_acc) begin
                    rptr    <= rptr + 1'b1;
                    rd_data <= mem[rptr];
                end
                count <= count_nxt;
                full  <= (count_nxt == FULL_CNT);
                empty <= (count_nxt == '0);
            end
        end

`ifdef DUAL_FIFO_ERR_EN
        logic ovf;
        logic udf;
        logic ovf_evt;
        logic udf_evt;

        assign ovf_evt = sel & fifo_wr_en & ~wr_acc;
        assign udf_evt = sel & fifo_rd_en & empty;

        // Set events take priority over err_clr.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                ovf <= ovf_evt | (ovf & ~err_clr);
                udf <= udf_evt | (udf & ~err_clr);
            end
        end
`endif
    end

    assign fifo1_rd_data = g_fifo[0].rd_data;
    assign fifo2_rd_data = g_fifo[1].rd_data;
    assign fifo1_full    = g_fifo[0].full;
    assign fifo1_empty   = g_fifo[0].empty;
    assign fifo2_full    = g_fifo[1].full;
    assign fifo2_empty   = g_fifo[1].empty;
    assign fifo1_count   = g_fifo[0].count;
    assign fifo2_count   = g_fifo[1].count;

`ifdef DUAL_FIFO_ERR_EN
    assign fifo1_ovf = g_fifo[0].ovf;
    assign fifo1_udf = g_fifo[0].udf;
    assign fifo2_ovf = g_fifo[1].ovf;
    assign fifo2_udf = g_fifo[1].udf;
`endif

endmodule

// File: tb/tb_dual_fifo_bank.sv
// Scoreboard bench for dual_fifo_bank: stimulus pushes expected read words, a monitor pops and checks rd_data.
`timescale 1ns/1ps
module tb_dual_fifo_bank;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_rd_en = 1'b0;
    logic        fifo_wr_en = 1'b0;
    logic        fifo_choose = 1'b0;
    logic [15:0] fifo1_wr_data = '0;
    logic [15:0] fifo2_wr_data = '0;
    logic [15:0] fifo1_rd_data;
    logic [15:0] fifo2_rd_data;
    logic        fifo1_full;
    logic        fifo1_empty;
    logic        fifo2_full;
    logic        fifo2_empty;
    logic [4:0]  fifo1_count;
    logic [4:0]  fifo2_count;
`ifdef DUAL_FIFO_ERR_EN
    logic        err_clr = 1'b0;
    logic        fifo1_ovf;
    logic        fifo1_udf;
    logic        fifo2_ovf;
    logic        fifo2_udf;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] mdl1 [$];
    logic [15:0] mdl2 [$];
    logic [15:0] sb1 [$];
    logic [15:0] sb2 [$];
    logic [1:0]  rd_exp = 2'b00;
    logic [15:0] last1 = '0;
    logic [15:0] last2 = '0;
    logic [1:0]  cap;

    dual_fifo_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef DUAL_FIFO_ERR_EN
        .err_clr       (err_clr),
        .fifo1_ovf     (fifo1_ovf),
        .fifo1_udf     (fifo1_udf),
        .fifo2_ovf     (fifo2_ovf),
        .fifo2_udf     (fifo2_udf),
`endif
        .fifo_rd_en    (fifo_rd_en),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_choose   (fifo_choose),
        .fifo1_wr_data (fifo1_wr_data),
        .fifo2_wr_data (fifo2_wr_data),
        .fifo1_rd_data (fifo1_rd_data),
        .fifo2_rd_data (fifo2_rd_data),
        .fifo1_full    (fifo1_full),
        .fifo1_empty   (fifo1_empty),
        .fifo2_full    (fifo2_full),
        .fifo2_empty   (fifo2_empty),
        .fifo1_count   (fifo1_count),
        .fifo2_count   (fifo2_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, " fifo1 status"}, 32'({fifo1_count, fifo1_full, fifo1_empty}),
            32'({5'(mdl1.size()), mdl1.size() == DEPTH, mdl1.size() == 0}));
        chk({tag, " fifo2 status"}, 32'({fifo2_count, fifo2_full, fifo2_empty}),
            32'({5'(mdl2.size()), mdl2.size() == DEPTH, mdl2.size() == 0}));
    endtask

    // One clock of stimulus; the queue model decides acceptance and feeds the scoreboard.
    task automatic step(input logic ch, input logic rd, input logic wr,
                        input logic [15:0] d1, input logic [15:0] d2, input string tag);
        bit racc;
        bit wacc;
        int n;
        @(negedge clk);
        fifo_choose   = ch;
        fifo_rd_en    = rd;
        fifo_wr_en    = wr;
        fifo1_wr_data = d1;
        fifo2_wr_data = d2;
        n    = ch ? mdl2.size() : mdl1.size();
        racc = rd && (n > 0);
        wacc = wr && ((n < DEPTH) || racc);
        rd_exp = 2'b00;
        if (!ch) begin
            if (racc) sb1.push_back(mdl1.pop_front());
            if (wacc) mdl1.push_back(d1);
        end else begin
            if (racc) sb2.push_back(mdl2.pop_front());
            if (wacc) mdl2.push_back(d2);
        end
        rd_exp[ch] = racc;
        @(posedge clk);
        #1;
        rd_exp = 2'b00;
        chk_status(tag);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cap = rd_exp;
            #1;
            if (!rst_n) begin
                last1 = '0;
                last2 = '0;
            end else begin
                if (cap[0]) begin
                    if (sb1.size() == 0) chk("fifo1 scoreboard empty", 32'd1, 32'd0);
                    else last1 = sb1.pop_front();
                end
                if (cap[1]) begin
                    if (sb2.size() == 0) chk("fifo2 scoreboard empty", 32'd1, 32'd0);
                    else last2 = sb2.pop_front();
                end
                chk("fifo1_rd_data", 32'(fifo1_rd_data), 32'(last1));
                chk("fifo2_rd_data", 32'(fifo2_rd_data), 32'(last2));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_status("reset");
        chk("reset fifo1_rd_data", 32'(fifo1_rd_data), 32'h0);
        chk("reset fifo2_rd_data", 32'(fifo2_rd_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 16; i++) step(1'b0, 1'b0, 1'b1, 16'(i), 16'h0, "fill1");
        chk("fill1 count", 32'(fifo1_count), 32'd16);
        chk("fill1 full", 32'(fifo1_full), 32'd1);

        step(1'b0, 1'b0, 1'b1, 16'hDEAD, 16'h0, "write when full");
        chk("drop count", 32'(fifo1_count), 32'd16);
`ifdef DUAL_FIFO_ERR_EN
        chk("fifo1_ovf", 32'(fifo1_ovf), 32'd1);
        chk("fifo2_ovf", 32'(fifo2_ovf), 32'd0);
`endif

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'h7777, 16'hA5A5, "iso fifo2");
        chk("iso fifo1_count", 32'(fifo1_count), 32'd16);
        chk("iso fifo2_count", 32'(fifo2_count), 32'd3);

        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, "drain1");
            chk("drain1 data", 32'(fifo1_rd_data), 32'(i));
        end
        chk("drain1 empty", 32'(fifo1_empty), 32'd1);

        step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, "read empty");
        chk("read empty hold", 32'(fifo1_rd_data), 32'h10);

        step(1'b0, 1'b1, 1'b1, 16'h0100, 16'h0, "rd+wr empty");
        chk("rd+wr empty count", 32'(fifo1_count), 32'd1);
        chk("rd+wr empty hold", 32'(fifo1_rd_data), 32'h10);

        for (int i = 1; i < 16; i++) step(1'b0, 1'b0, 1'b1, 16'h0100 + 16'(i), 16'h0, "refill1");
        step(1'b0, 1'b1, 1'b1, 16'h0200, 16'h0, "rd+wr full");
        chk("rd+wr full count", 32'(fifo1_count), 32'd16);
        chk("rd+wr full oldest", 32'(fifo1_rd_data), 32'h0100);

        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, "drain1b");
        chk("drain1b last", 32'(fifo1_rd_data), 32'h0200);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, "drain2");
        chk("drain2 data", 32'(fifo2_rd_data), 32'hA5A5);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++)
                step(1'b0, 1'b0, 1'b1, 16'h0300 + 16'(r * 5 + k), 16'h0, "wrap wr");
            for (int k = 0; k < 5; k++)
                step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, "wrap rd");
        end
        chk("wrap last", 32'(fifo1_rd_data), 32'h0313);

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 16'h0, 16'h0400 + 16'(i), "pre-reset fill");
        step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, "pre-reset read");
        chk("pre-reset count", 32'(fifo2_count), 32'd7);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst fifo2_count", 32'(fifo2_count), 32'd0);
        chk("async rst fifo2_empty", 32'(fifo2_empty), 32'd1);
        chk("async rst fifo2_full", 32'(fifo2_full), 32'd0);
        chk("async rst fifo2_rd_data", 32'(fifo2_rd_data), 32'h0);
        chk("async rst fifo1_rd_data", 32'(fifo1_rd_data), 32'h0);
        mdl1.delete();
        mdl2.delete();
        sb1.delete();
        sb2.delete();
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 1'b0, 1'b1, 16'h0, 16'hBEEF, "post-reset wr");
        step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, "post-reset rd");
        chk("post-reset data", 32'(fifo2_rd_data), 32'hBEEF);
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, "idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
